// File: rtl/secded_scrub_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : secded_scrub_ctrl                                              |
// | Purpose  : SECDED result consumer: scrub write-back queue, CE/UCE         |
// |            saturating counters, first-UCE capture and level interrupt.    |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module secded_scrub_ctrl #(
  parameter int AW        = 32,
  parameter int DEPTH     = 2,
  parameter int CW        = 8,
  parameter int CE_THRESH = 16
) (
  input  logic          s_clk_i,
  input  logic          s_resetn_i,
  input  logic          s_rvalid_i,
  input  logic          s_error_i,
  input  logic          s_ce_i,
  input  logic [AW-1:0] s_raddr_i,
  input  logic [31:0]   s_rdata_i,
  input  logic [6:0]    s_rchecksum_i,
  output logic          s_scrub_valid_o,
  input  logic          s_scrub_ready_i,
  output logic [AW-1:0] s_scrub_addr_o,
  output logic [31:0]   s_scrub_data_o,
  output logic [6:0]    s_scrub_checksum_o,
  output logic [CW-1:0] s_ce_cnt_o,
  output logic [CW-1:0] s_uce_cnt_o,
  output logic          s_uce_valid_o,
  output logic [AW-1:0] s_uce_addr_o,
  output logic          s_drop_o,
  input  logic          s_clr_i,
  output logic          s_irq_o
);

  localparam int              c_PW      = $clog2(DEPTH + 1);
  localparam int              c_IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0]   c_CNT_MAX = '1;
  localparam logic [c_PW-1:0] c_DEPTH   = c_PW'(DEPTH);
  localparam logic [c_IW-1:0] c_LAST    = c_IW'(DEPTH - 1);

  // Scrub queue storage: circular buffer with per-slot valid bits for dedup
  logic [AW-1:0]    r_addr [DEPTH];
  logic [31:0]      r_data [DEPTH];
  logic [6:0]       r_csum [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [c_IW-1:0]  r_rd_ptr;
  logic [c_IW-1:0]  r_wr_ptr;
  logic [c_PW-1:0]  r_count;

  logic [CW-1:0]    r_ce_cnt;
  logic [CW-1:0]    r_uce_cnt;
  logic             r_uce_valid;
  logic [AW-1:0]    r_uce_addr;
  logic             r_drop;
  logic             r_irq;

  logic             w_ce;
  logic             w_uce;
  logic             w_pop;
  logic             w_full;
  logic [DEPTH-1:0] w_hit;
  logic             w_dup;
  logic             w_push;
  logic             w_drop;

  logic [CW-1:0]    w_ce_base;
  logic [CW-1:0]    w_uce_base;
  logic [CW-1:0]    w_ce_nxt;
  logic [CW-1:0]    w_uce_nxt;
  logic             w_uv_nxt;
  logic [AW-1:0]    w_ua_nxt;
  logic             w_thr;
  logic             w_irq_nxt;

  function automatic logic [c_IW-1:0] f_inc(input logic [c_IW-1:0] p);
    return (p == c_LAST) ? '0 : p + 1'b1;
  endfunction

  assign w_ce   = s_rvalid_i & s_error_i & s_ce_i;
  assign w_uce  = s_rvalid_i & s_error_i & ~s_ce_i;
  assign w_pop  = (r_count != '0) & s_scrub_ready_i;
  assign w_full = (r_count == c_DEPTH);

  // Dedup looks at every entry valid at the start of the cycle, head included
  for (genvar i = 0; i < DEPTH; i++) begin : g_dup
    assign w_hit[i] = r_vld[i] & (r_addr[i] == s_raddr_i);
  end
  assign w_dup  = |w_hit;

  assign w_drop = w_ce & ~w_dup & w_full & ~w_pop;
  assign w_push = w_ce & ~w_dup & (~w_full | w_pop);

  always_ff @(posedge s_clk_i) begin
    if (!s_resetn_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_addr[i] <= '0;
        r_data[i] <= '0;
        r_csum[i] <= '0;
      end
      r_vld    <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_pop) begin
        r_vld[r_rd_ptr] <= 1'b0;
        r_rd_ptr        <= f_inc(r_rd_ptr);
      end
      // Set after clear: a full queue may pop and push the same slot
      if (w_push) begin
        r_addr[r_wr_ptr] <= s_raddr_i;
        r_data[r_wr_ptr] <= s_rdata_i;
        r_csum[r_wr_ptr] <= s_rchecksum_i;
        r_vld[r_wr_ptr]  <= 1'b1;
        r_wr_ptr         <= f_inc(r_wr_ptr);
      end
      r_count <= r_count + c_PW'(w_push) - c_PW'(w_pop);
    end
  end

  // Clear applies first, so a same-cycle event lands on a zeroed state
  always_comb begin
    w_ce_base  = s_clr_i ? '0 : r_ce_cnt;
    w_uce_base = s_clr_i ? '0 : r_uce_cnt;
    w_ce_nxt   = w_ce_base;
    w_uce_nxt  = w_uce_base;
    if (w_ce && (w_ce_base != c_CNT_MAX)) begin
      w_ce_nxt = w_ce_base + 1'b1;
    end
    if (w_uce && (w_uce_base != c_CNT_MAX)) begin
      w_uce_nxt = w_uce_base + 1'b1;
    end
    w_uv_nxt = s_clr_i ? 1'b0 : r_uce_valid;
    w_ua_nxt = s_clr_i ? '0 : r_uce_addr;
    if (w_uce && !w_uv_nxt) begin
      w_uv_nxt = 1'b1;
      w_ua_nxt = s_raddr_i;
    end
    w_thr     = (CE_THRESH != 0) && (32'(w_ce_nxt) >= 32'(CE_THRESH));
    w_irq_nxt = w_uv_nxt | w_thr;
  end

  always_ff @(posedge s_clk_i) begin
    if (!s_resetn_i) begin
      r_ce_cnt    <= '0;
      r_uce_cnt   <= '0;
      r_uce_valid <= 1'b0;
      r_uce_addr  <= '0;
      r_drop      <= 1'b0;
      r_irq       <= 1'b0;
    end else begin
      r_ce_cnt    <= w_ce_nxt;
      r_uce_cnt   <= w_uce_nxt;
      r_uce_valid <= w_uv_nxt;
      r_uce_addr  <= w_ua_nxt;
      r_drop      <= w_drop;
      r_irq       <= w_irq_nxt;
    end
  end

  assign s_scrub_valid_o    = (r_count != '0);
  assign s_scrub_addr_o     = r_addr[r_rd_ptr];
  assign s_scrub_data_o     = r_data[r_rd_ptr];
  assign s_scrub_checksum_o = r_csum[r_rd_ptr];
  assign s_ce_cnt_o         = r_ce_cnt;
  assign s_uce_cnt_o        = r_uce_cnt;
  assign s_uce_valid_o      = r_uce_valid;
  assign s_uce_addr_o       = r_uce_addr;
  assign s_drop_o           = r_drop;
  assign s_irq_o            = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_secded_scrub_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_secded_scrub_ctrl                                           |
// | Purpose  : Directed + random bench for secded_scrub_ctrl, queue model.    |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_secded_scrub_ctrl;

  localparam int AW        = 32;
  localparam int DEPTH     = 2;
  localparam int CW        = 4;
  localparam int CE_THRESH = 3;
  localparam int MAXC      = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          resetn, rvalid, error, ce, scrub_ready, clr;
  logic [AW-1:0] raddr;
  logic [31:0]   rdata;
  logic [6:0]    rcsum;
  logic          scrub_valid, uce_valid, drop, irq;
  logic [AW-1:0] scrub_addr, uce_addr;
  logic [31:0]   scrub_data;
  logic [6:0]    scrub_csum;
  logic [CW-1:0] ce_cnt, uce_cnt;

  always #5 clk = ~clk;

  secded_scrub_ctrl #(.AW(AW), .DEPTH(DEPTH), .CW(CW), .CE_THRESH(CE_THRESH)) dut (
    .s_clk_i(clk), .s_resetn_i(resetn), .s_rvalid_i(rvalid), .s_error_i(error),
    .s_ce_i(ce), .s_raddr_i(raddr), .s_rdata_i(rdata), .s_rchecksum_i(rcsum),
    .s_scrub_valid_o(scrub_valid), .s_scrub_ready_i(scrub_ready),
    .s_scrub_addr_o(scrub_addr), .s_scrub_data_o(scrub_data),
    .s_scrub_checksum_o(scrub_csum), .s_ce_cnt_o(ce_cnt), .s_uce_cnt_o(uce_cnt),
    .s_uce_valid_o(uce_valid), .s_uce_addr_o(uce_addr), .s_drop_o(drop),
    .s_clr_i(clr), .s_irq_o(irq)
  );

  typedef struct packed {
    logic [AW-1:0] a;
    logic [31:0]   d;
    logic [6:0]    c;
  } ent_t;

  ent_t          q[$];
  int            m_ce, m_uce;
  bit            m_uv, m_drop, m_irq;
  logic [AW-1:0] m_ua;
  int            checks = 0;
  int            errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: in-order queue plus saturating integer counters
  task automatic model_update();
    bit   mce, muce, pop, dup, full;
    ent_t e;
    if (!resetn) begin
      q.delete();
      m_ce = 0; m_uce = 0; m_uv = 0; m_ua = '0; m_drop = 0; m_irq = 0;
      return;
    end
    mce  = rvalid && error && ce;
    muce = rvalid && error && !ce;
    pop  = (q.size() > 0) && scrub_ready;
    dup  = 0;
    foreach (q[i]) if (q[i].a == raddr) dup = 1;
    full   = (q.size() == DEPTH);
    m_drop = mce && !dup && full && !pop;
    if (pop) void'(q.pop_front());
    if (mce && !dup && !m_drop) begin
      e.a = raddr; e.d = rdata; e.c = rcsum;
      q.push_back(e);
    end
    if (clr) begin
      m_ce = 0; m_uce = 0; m_uv = 0; m_ua = '0;
    end
    if (mce && m_ce < MAXC) m_ce++;
    if (muce && m_uce < MAXC) m_uce++;
    if (muce && !m_uv) begin
      m_uv = 1; m_ua = raddr;
    end
    m_irq = m_uv || (m_ce >= CE_THRESH);
  endtask

  task automatic compare_all();
    chk("scrub_valid", scrub_valid, q.size() > 0);
    if (q.size() > 0) begin
      chk("scrub_addr", scrub_addr, q[0].a);
      chk("scrub_data", scrub_data, q[0].d);
      chk("scrub_csum", scrub_csum, q[0].c);
    end
    chk("ce_cnt", ce_cnt, m_ce);
    chk("uce_cnt", uce_cnt, m_uce);
    chk("uce_valid", uce_valid, m_uv);
    chk("uce_addr", uce_addr, m_ua);
    chk("drop", drop, m_drop);
    chk("irq", irq, m_irq);
  endtask

  task automatic cycle();
    model_update();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic set_in(input bit rv, input bit er, input bit c, input logic [AW-1:0] a,
                        input logic [31:0] d, input bit rdy, input bit cl);
    rvalid = rv; error = er; ce = c; raddr = a; rdata = d;
    rcsum = d[6:0] ^ d[31:25]; scrub_ready = rdy; clr = cl;
  endtask

  task automatic idle(input bit rdy);
    set_in(0, 0, 0, '0, '0, rdy, 0);
  endtask

  initial begin
    resetn = 0;
    idle(0);

    // Reset held with an error beat present
    set_in(1, 1, 0, 32'h55, 32'h1234, 1, 0);
    for (int i = 0; i < 2; i++) begin
      cycle();
      chk("rst_valid", scrub_valid, 0);
      chk("rst_addr", scrub_addr, 0);
      chk("rst_data", scrub_data, 0);
      chk("rst_csum", scrub_csum, 0);
      chk("rst_uce_cnt", uce_cnt, 0);
      chk("rst_irq", irq, 0);
    end
    resetn = 1;
    idle(0);
    cycle();
    chk("rel_uce_valid", uce_valid, 0);
    chk("rel_valid", scrub_valid, 0);

    // CE scrub with ready high
    set_in(1, 1, 1, 32'h100, 32'hDEADBEEF, 1, 0);
    cycle();
    chk("ce_valid", scrub_valid, 1);
    chk("ce_addr", scrub_addr, 32'h100);
    chk("ce_data", scrub_data, 32'hDEADBEEF);
    chk("ce_cnt1", ce_cnt, 1);
    idle(1);
    cycle();
    chk("ce_gone", scrub_valid, 0);

    // Backpressure and full-queue drop
    set_in(0, 0, 0, '0, '0, 0, 1);
    cycle();
    set_in(1, 1, 1, 32'h10, 32'hA0, 0, 0); cycle();
    set_in(1, 1, 1, 32'h20, 32'hB0, 0, 0); cycle();
    chk("bp_nodrop", drop, 0);
    set_in(1, 1, 1, 32'h30, 32'hC0, 0, 0); cycle();
    chk("bp_drop", drop, 1);
    chk("bp_cnt", ce_cnt, 3);
    chk("bp_head", scrub_addr, 32'h10);
    idle(1); cycle();
    chk("bp_drop_pulse", drop, 0);
    chk("bp_head2", scrub_addr, 32'h20);
    idle(1); cycle();
    chk("bp_empty", scrub_valid, 0);

    // Dedup of back-to-back CE at same address
    set_in(0, 0, 0, '0, '0, 0, 1); cycle();
    set_in(1, 1, 1, 32'h40, 32'h4444, 0, 0); cycle();
    set_in(1, 1, 1, 32'h40, 32'h4444, 0, 0); cycle();
    chk("dd_cnt", ce_cnt, 2);
    chk("dd_drop", drop, 0);
    idle(1); cycle();
    chk("dd_single", scrub_valid, 0);

    // UCE capture and clear
    set_in(0, 0, 0, '0, '0, 0, 1); cycle();
    set_in(1, 1, 0, 32'h200, 32'h0, 0, 0); cycle();
    set_in(1, 1, 0, 32'h300, 32'h0, 0, 0); cycle();
    chk("uce_addr", uce_addr, 32'h200);
    chk("uce_cnt2", uce_cnt, 2);
    chk("uce_irq", irq, 1);
    set_in(0, 0, 0, '0, '0, 0, 1); cycle();
    chk("clr_uce_valid", uce_valid, 0);
    chk("clr_irq", irq, 0);
    set_in(1, 1, 0, 32'h400, 32'h0, 0, 0); cycle();
    set_in(1, 1, 0, 32'h500, 32'h0, 0, 1); cycle();
    chk("clr_recapture", uce_addr, 32'h500);
    chk("clr_recap_cnt", uce_cnt, 1);

    // Saturation and CE threshold
    set_in(0, 0, 0, '0, '0, 1, 1); cycle();
    for (int i = 0; i < 20; i++) begin
      set_in(1, 1, 1, 32'h1000 + 32'(i * 4), $urandom, 1, 0);
      cycle();
      if (i == 1) chk("thr_below", irq, 0);
      if (i == 2) chk("thr_at", irq, 1);
    end
    chk("sat_cnt", ce_cnt, 15);
    set_in(1, 1, 1, 32'h2000, 32'h77, 1, 1); cycle();
    chk("clr_ce_cnt", ce_cnt, 1);
    chk("clr_ce_irq", irq, 0);

    // Reset with a pending scrub
    idle(0); cycle();
    set_in(1, 1, 1, 32'h600, 32'h66, 0, 0); cycle();
    resetn = 0; idle(0); cycle();
    chk("rst_mid_valid", scrub_valid, 0);
    resetn = 1; cycle();

    // Randomized traffic over a small address pool to hit dedup and full
    for (int i = 0; i < 600; i++) begin
      set_in($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0,
             32'($urandom_range(0, 5)) << 4, $urandom, $urandom_range(0, 2) == 0,
             $urandom_range(0, 40) == 0);
      resetn = ($urandom_range(0, 99) != 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
